// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK link serializer/deserializer pair.
//
// Contents:
//   rx_state_t       receive framing state: HUNT (waiting for sync), SHIFT (aligned)
//   BPSK_WORD_WIDTH  default word width shared with the transmit serializer
//   BPSK_CNT_WIDTH   default bit-counter width; BPSK_WORD_WIDTH <= 2**BPSK_CNT_WIDTH
package bpsk_pkg;

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  localparam int unsigned BPSK_WORD_WIDTH = 16;
  localparam int unsigned BPSK_CNT_WIDTH  = 4;

endpackage

// File: rtl/word_holding_reg.sv
// Single-entry valid/ready holding register for completed receive words.
//
// A load request is accepted when the register is empty or is being drained in
// the same cycle; otherwise the incoming word is dropped and the sticky overrun
// flag is raised. All outputs are registered.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   load         a completed word is offered this cycle
//   word         the offered word
//   out_ready    downstream accepts the held word when data_valid is also 1
//   clr_overrun  clears the sticky overrun flag (a same-cycle new overrun wins)
//   data         held word, stable while data_valid is 1
//   data_valid   register holds an unconsumed word
//   overrun      sticky: a completed word was dropped
module word_holding_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             handshake;
  logic             accept;

  always_comb begin
    handshake = valid_q && out_ready;
    // Space exists if empty now, or if the held word leaves this very cycle.
    accept    = load && (!valid_q || out_ready);

    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (accept) begin
      data_d  = word;
      valid_d = 1'b1;
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    if (load && !accept) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/serial_parallel.sv
// Receive-side deserializer for the BPSK link.
//
// Collects one demodulated bit per bit_valid strobe into WIDTH-bit words, LSB
// first (first bit received lands in bit 0). A sync marker aligns the frame;
// once aligned the block free-runs over back-to-back words. Completed words are
// handed to a single-entry valid/ready holding register that flags drops.
//
// Parameters:
//   WIDTH  word width in bits
//   N      bit-counter width, WIDTH <= 2**N
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   serial_signal  received bit, sampled when bit_valid is 1
//   bit_valid      one-cycle strobe marking a bit
//   sync           qualified by bit_valid: current bit is bit 0 of a new word
//   out_ready      downstream ready
//   clr_overrun    clears the sticky overrun flag
//   parallel_data  held word
//   data_valid     held word not yet consumed
//   overrun        sticky word-dropped flag
//   locked         frame aligned (state SHIFT)
module serial_parallel
  import bpsk_pkg::*;
#(
  parameter int unsigned WIDTH = BPSK_WORD_WIDTH,
  parameter int unsigned N     = BPSK_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_signal,
  input  logic             bit_valid,
  input  logic             sync,
  input  logic             out_ready,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] parallel_data,
  output logic             data_valid,
  output logic             overrun,
  output logic             locked
);

  localparam logic [N-1:0] LastIdx = N'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [N-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             locked_q;

  logic             take_bit;
  logic [N-1:0]     wr_idx;
  logic             word_done;

  always_comb begin
    // In HUNT only a sync-marked bit is accepted; in SHIFT every strobe is.
    take_bit  = bit_valid && ((state_q == SHIFT) || sync);
    // sync always restarts the word at bit 0, discarding any partial word.
    wr_idx    = sync ? '0 : cnt_q;
    word_done = take_bit && (wr_idx == LastIdx);

    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;

    if (take_bit) begin
      if (sync) begin
        shift_d = '0;
      end
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (wr_idx == N'(i)) begin
          shift_d[i] = serial_signal;
        end
      end
      cnt_d   = word_done ? '0 : wr_idx + N'(1);
      state_d = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      shift_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      locked_q <= (state_d == SHIFT);
    end
  end

  assign locked = locked_q;

  // shift_d already carries the final bit, so the word loads with 1-cycle latency.
  word_holding_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (word_done),
    .word       (shift_d),
    .out_ready  (out_ready),
    .clr_overrun(clr_overrun),
    .data       (parallel_data),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_parallel.sv
module tb_serial_parallel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        serial_signal;
  logic        bit_valid;
  logic        sync;
  logic        out_ready;
  logic        clr_overrun;
  logic [15:0] parallel_data;
  logic        data_valid;
  logic        overrun;
  logic        locked;

  int          total = 0;
  int          bad = 0;
  int          delivered = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  serial_parallel #(
    .WIDTH(16),
    .N    (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_signal(serial_signal),
    .bit_valid    (bit_valid),
    .sync         (sync),
    .out_ready    (out_ready),
    .clr_overrun  (clr_overrun),
    .parallel_data(parallel_data),
    .data_valid   (data_valid),
    .overrun      (overrun),
    .locked       (locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after a rising edge; the next edge samples them.
  // Returns 2 units after the edge that sampled the last bit.
  task automatic send_bits(input logic [15:0] w, input int n, input bit first_sync,
                           input bit ready_last);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      bit_valid     = 1'b1;
      serial_signal = w[i];
      sync          = first_sync && (i == 0);
      if (ready_last && (i == n - 1)) out_ready = 1'b1;
    end
    @(posedge clk); #2;
    bit_valid     = 1'b0;
    sync          = 1'b0;
    serial_signal = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
    end
  endtask

  // Scoreboard: every handshake the DUT completes must match the oldest expected word.
  logic [15:0] exp_word;
  always @(negedge clk) begin
    if (rst_n && data_valid && out_ready) begin
      total++;
      assert (sb.size() != 0)
      else begin
        bad++;
        $error("FAIL sb_unexpected: observed=%0h expected=none", parallel_data);
      end
      if (sb.size() != 0) begin
        exp_word = sb.pop_front();
        delivered++;
        total++;
        assert (parallel_data === exp_word)
        else begin
          bad++;
          $error("FAIL sb_word: observed=%0h expected=%0h", parallel_data, exp_word);
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    serial_signal = 1'b0;
    bit_valid     = 1'b0;
    sync          = 1'b0;
    out_ready     = 1'b0;
    clr_overrun   = 1'b0;
    idle(3);
    check("rst_data", 32'(parallel_data), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Basic word, immediate delivery.
    out_ready = 1'b1;
    sb.push_back(16'hA5C3);
    send_bits(16'hA5C3, 16, 1'b1, 1'b0);
    check("t1_valid", 32'(data_valid), 32'h1);
    check("t1_data", 32'(parallel_data), 32'hA5C3);
    check("t1_locked", 32'(locked), 32'h1);
    idle(1);
    check("t1_valid_drop", 32'(data_valid), 32'h0);

    // Strobes without sync are ignored in HUNT.
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    send_bits(16'hFFFF, 8, 1'b0, 1'b0);
    check("t2_locked", 32'(locked), 32'h0);
    check("t2_valid", 32'(data_valid), 32'h0);
    sb.push_back(16'h0001);
    send_bits(16'h0001, 16, 1'b1, 1'b0);
    check("t2_data", 32'(parallel_data), 32'h0001);
    idle(1);

    // Overrun: second word dropped, first kept.
    out_ready = 1'b0;
    sb.push_back(16'h1234);
    send_bits(16'h1234, 16, 1'b1, 1'b0);
    check("t3_valid", 32'(data_valid), 32'h1);
    check("t3_ovr0", 32'(overrun), 32'h0);
    send_bits(16'hFFFF, 16, 1'b0, 1'b0);
    check("t3_ovr1", 32'(overrun), 32'h1);
    check("t3_data_kept", 32'(parallel_data), 32'h1234);
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    check("t3_ovr_clr", 32'(overrun), 32'h0);
    check("t3_valid_kept", 32'(data_valid), 32'h1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("t3_drained", 32'(data_valid), 32'h0);

    // Word completes on the same cycle the previous word is handed off.
    sb.push_back(16'hC0DE);
    send_bits(16'hC0DE, 16, 1'b0, 1'b0);
    sb.push_back(16'h3C96);
    send_bits(16'h3C96, 16, 1'b0, 1'b1);
    check("t4_valid", 32'(data_valid), 32'h1);
    check("t4_data", 32'(parallel_data), 32'h3C96);
    check("t4_ovr", 32'(overrun), 32'h0);
    idle(1);
    check("t4_drained", 32'(data_valid), 32'h0);

    // Re-alignment: partial word of 9 bits, then sync restarts the word.
    send_bits(16'h5555, 9, 1'b1, 1'b0);
    check("t5_no_partial", 32'(data_valid), 32'h0);
    check("t5_locked", 32'(locked), 32'h1);
    sb.push_back(16'h00FF);
    send_bits(16'h00FF, 16, 1'b1, 1'b0);
    check("t5_data", 32'(parallel_data), 32'h00FF);
    check("t5_ovr", 32'(overrun), 32'h0);
    idle(1);

    // Reset mid-word with a word held.
    out_ready = 1'b0;
    send_bits(16'hBEEF, 16, 1'b1, 1'b0);
    check("t6_held", 32'(data_valid), 32'h1);
    send_bits(16'h007F, 7, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n         = 1'b0;
    bit_valid     = 1'b1;
    serial_signal = 1'b1;
    @(posedge clk); #2;
    bit_valid     = 1'b0;
    serial_signal = 1'b0;
    rst_n         = 1'b1;
    check("t6_data", 32'(parallel_data), 32'h0);
    check("t6_valid", 32'(data_valid), 32'h0);
    check("t6_ovr", 32'(overrun), 32'h0);
    check("t6_locked", 32'(locked), 32'h0);
    out_ready = 1'b1;
    sb.push_back(16'h5A5A);
    send_bits(16'h5A5A, 16, 1'b1, 1'b0);
    check("t6_new_data", 32'(parallel_data), 32'h5A5A);
    idle(2);

    check("sb_empty", 32'(sb.size()), 32'h0);
    check("delivered", 32'(delivered), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
